// File: rtl/if_prefetch_queue.sv
// rtl/if_prefetch_queue.sv - instruction prefetch sequencer and PC+4 FIFO feeding IF/ID
// Optional same-cycle ack-to-output bypass when IF_PREFETCH_BYPASS_EN is defined.
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ins_valid,
    output logic [31:0] ins_out,
    output logic [31:0] ins_pc4,
    input  logic        ins_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [31:0]      fetch_pc;
    logic [31:0]      fetch_pc_next;
    logic [31:0]      addr_next;
    logic [31:0]      pc_plus4;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      mem_ins [DEPTH];
    logic [31:0]      mem_pc4 [DEPTH];
    logic             ack_ok;
    logic             bypass;
    logic             push;
    logic             pop;
    logic             fifo_valid;

    always_comb begin
        pc_plus4      = fetch_pc + 32'd4;
        fifo_valid    = (count != '0);
        ack_ok        = (state == S_WAIT) && imem_ack && !redirect;
`ifdef IF_PREFETCH_BYPASS_EN
        bypass        = ack_ok && !fifo_valid;
`else
        bypass        = 1'b0;
`endif
        // A bypassed word taken by the consumer this cycle never enters the FIFO.
        push          = ack_ok && !(bypass && ins_ready);
        pop           = fifo_valid && ins_ready && !redirect;
        count_next    = redirect ? '0 : (count + CNT_W'(push) - CNT_W'(pop));
        state_next    = state;
        fetch_pc_next = fetch_pc;

        case (state)
            S_IDLE: begin
                if (redirect) begin
                    fetch_pc_next = redirect_pc;
                end else if (count_next < FULL) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    fetch_pc_next = redirect_pc;
                    state_next    = imem_ack ? S_IDLE : S_DROP;
                end else if (imem_ack) begin
                    fetch_pc_next = pc_plus4;
                    state_next    = (count_next < FULL) ? S_WAIT : S_IDLE;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    fetch_pc_next = redirect_pc;
                end
                if (imem_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // The abandoned request keeps its original address until it is acknowledged.
        addr_next = (state_next == S_DROP) ? imem_addr : fetch_pc_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_PC;
            imem_addr <= RESET_PC;
            imem_req  <= 1'b0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_ins[i] <= '0;
                mem_pc4[i] <= '0;
            end
        end else begin
            state     <= state_next;
            fetch_pc  <= fetch_pc_next;
            imem_addr <= addr_next;
            imem_req  <= (state_next != S_IDLE);
            count     <= count_next;
            if (push) begin
                mem_ins[wr_ptr] <= imem_rdata;
                mem_pc4[wr_ptr] <= pc_plus4;
            end
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    assign ins_valid = fifo_valid || bypass;
    assign ins_out   = bypass ? imem_rdata : mem_ins[rd_ptr];
    assign ins_pc4   = bypass ? pc_plus4   : mem_pc4[rd_ptr];

endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb/tb_if_prefetch_queue.sv - directed and randomized bench for if_prefetch_queue
module tb_if_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        ins_valid;
    logic [31:0] ins_out;
    logic [31:0] ins_pc4;
    logic        ins_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ins_valid   (ins_valid),
        .ins_out     (ins_out),
        .ins_pc4     (ins_pc4),
        .ins_ready   (ins_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] q_addr [$];
    logic [31:0] next_fetch = RESET_PC;
    bit          drop_pending = 0;
    bit          after_redir = 0;
    bit          prev_pend = 0;
    logic [31:0] prev_addr = '0;
    int          req_age = 0;
    int          mem_delay = 0;
    int          lat_lo = 0;
    int          lat_hi = 0;
    int          pops = 0;
    int          p0 = 0;
    bit          cap_first = 0;
    logic [31:0] first_pc4 = '0;
    bit          wrap_seen = 0;

    // Memory contents are a fixed scramble of the address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        ins_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_ack    = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk("rst_ins_valid", ins_valid, 1'b0);
        chk("rst_ins_out", ins_out, 32'h0);
        chk("rst_ins_pc4", ins_pc4, 32'h0);
        rst = 1'b0;
        q_addr.delete();
        next_fetch   = RESET_PC;
        drop_pending = 0;
        after_redir  = 0;
        prev_pend    = 0;
        req_age      = 0;
        mem_delay    = $urandom_range(lat_hi, lat_lo);
    endtask

    task automatic cyc(input bit rdy, input bit rd, input logic [31:0] rpc);
        logic        acc;
        logic        bypass_now;
        logic        exp_valid;
        logic [31:0] head;
        ins_ready   = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ack    = imem_req && (req_age >= mem_delay);
        imem_rdata  = drop_pending ? $urandom : word_of(imem_addr);
        #3;
        acc = imem_req && imem_ack;
        if (after_redir) chk("req_after_redirect", imem_req, drop_pending);
        after_redir = 0;
        if (prev_pend) chk("addr_stable", imem_addr, prev_addr);
        if (imem_req && !drop_pending) chk("fetch_addr", imem_addr, next_fetch);
        if (q_addr.size() == DEPTH) chk("req_low_when_full", imem_req, 1'b0);
        bypass_now = 1'b0;
`ifdef IF_PREFETCH_BYPASS_EN
        bypass_now = acc && !rd && !drop_pending && (q_addr.size() == 0);
`endif
        exp_valid = (q_addr.size() > 0) || bypass_now;
        chk("ins_valid", ins_valid, exp_valid);
        head = bypass_now ? imem_addr : ((q_addr.size() > 0) ? q_addr[0] : 32'h0);
        if (exp_valid) begin
            chk("ins_out", ins_out, word_of(head));
            chk("ins_pc4", ins_pc4, head + 32'd4);
        end
        if (rd) begin
            q_addr.delete();
            drop_pending = imem_req && !imem_ack;
            next_fetch   = rpc;
            after_redir  = 1;
        end else begin
            if (exp_valid && rdy) begin
                pops++;
                if (cap_first) begin
                    first_pc4 = head + 32'd4;
                    cap_first = 0;
                end
                if (head == 32'hFFFF_FFFC) wrap_seen = 1;
                if (!bypass_now) void'(q_addr.pop_front());
            end
            if (acc) begin
                if (drop_pending) begin
                    drop_pending = 0;
                end else begin
                    if (!(bypass_now && rdy)) q_addr.push_back(imem_addr);
                    next_fetch = next_fetch + 32'd4;
                end
            end
        end
        prev_pend = imem_req && !imem_ack;
        prev_addr = imem_addr;
        if (acc) begin
            req_age   = 0;
            mem_delay = $urandom_range(lat_hi, lat_lo);
        end else if (imem_req) begin
            req_age++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1;
        // Zero-wait memory, consumer always ready: one word per cycle.
        lat_lo = 0; lat_hi = 0;
        do_reset();
        cyc(1, 0, 0);
        chk("req_rises_after_idle", imem_req, 1'b1);
        cyc(1, 0, 0);
        p0 = pops;
        for (int i = 0; i < 16; i++) cyc(1, 0, 0);
        chk("throughput", pops - p0, 16);

        // Stalled consumer fills the FIFO with 0..12, then fetch resumes at 16.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(0, 0, 0);
        chk("full_req_low", imem_req, 1'b0);
        chk("full_valid", ins_valid, 1'b1);
        chk("full_head_pc4", ins_pc4, 32'd4);
        cyc(1, 0, 0);
        chk("resume_req", imem_req, 1'b1);
        chk("resume_addr", imem_addr, 32'd16);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0);

        // Redirect coinciding with an ack while two entries are buffered.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
        chk("two_buffered_pc4", ins_pc4, 32'd4);
        cyc(0, 1, 32'h0000_0200);
        chk("redir_ack_valid", ins_valid, 1'b0);
        chk("redir_ack_req", imem_req, 1'b0);
        cyc(1, 0, 0);
        chk("redir_ack_req2", imem_req, 1'b1);
        chk("redir_ack_addr", imem_addr, 32'h0000_0200);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0);

        // Redirect during a slow fetch: the stale response is dropped.
        lat_lo = 3; lat_hi = 3;
        do_reset();
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cap_first = 1;
        cyc(1, 1, 32'h0000_0100);
        chk("drop_req_held", imem_req, 1'b1);
        chk("drop_addr_held", imem_addr, RESET_PC);
        for (int i = 0; i < 14; i++) cyc(1, 0, 0);
        chk("first_after_redirect", first_pc4, 32'h0000_0104);

        // PC wrap past the top of the address space.
        lat_lo = 0; lat_hi = 1;
        cyc(1, 1, 32'hFFFF_FFF0);
        for (int i = 0; i < 14; i++) cyc(1, 0, 0);
        chk("pc_wrap_delivered", wrap_seen, 1'b1);

        // Randomized traffic with mid-run resets.
        lat_lo = 0; lat_hi = 3;
        p0 = pops;
        for (int i = 0; i < 800; i++) begin
            if (i % 250 == 249) begin
                do_reset();
            end else begin
                cyc(($urandom_range(9, 0) < 7), ($urandom_range(19, 0) == 0),
                    {$urandom_range(32'h3FFF_FFFF, 0), 2'b00});
            end
        end
        chk("random_progress", (pops - p0) > 100, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/if_prefetch_queue.md
# if_prefetch_queue

Instruction prefetch stage that sits directly upstream of the IF/ID pipeline register. It runs a single-outstanding request/acknowledge fetch sequencer against the instruction memory and buffers returned words, each with its PC+4, in a small FIFO. The FIFO head drives the IF/ID inputs, and `ins_ready` (the IF/ID write enable) pops it. A branch or jump redirect from the ID stage flushes the FIFO, discards any in-flight response, and restarts fetch at the new target.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, minimum 2.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1  — rising-edge clock.
- `rst`  in  1  — reset; synchronous, active-high.
- `imem_req`  out  1  — fetch request; held until `imem_ack`.
- `imem_addr`  out  32  — fetch address; stable while `imem_req` is high.
- `imem_ack`  in  1  — response valid; qualifies `imem_rdata`; only meaningful while `imem_req` is high.
- `imem_rdata`  in  32  — instruction word.
- `ins_valid`  out  1  — FIFO head valid.
- `ins_out`  out  32  — head instruction.
- `ins_pc4`  out  32  — head fetch address + 4.
- `ins_ready`  in  1  — consumer accepts the head (IF/ID write enable).
- `redirect`  in  1  — flush and restart fetch.
- `redirect_pc`  in  32  — new fetch address; sampled when `redirect` is high.

## Operation
- Registers:
  - `fetch_pc`: 32 bits.
  - `count`: 0..DEPTH.
  - Read and write pointers: log2(DEPTH) bits, wrap modulo DEPTH.
  - State: IDLE, WAIT, or DROP.
- Push: an accepted `imem_ack` in WAIT (no `redirect` that cycle) writes {`imem_rdata`, `fetch_pc`+4} at the write pointer and sets `fetch_pc` to `fetch_pc`+4.
- Pop: `ins_valid` & `ins_ready` & !`redirect` advances the read pointer.
- A push and a pop in the same cycle leave `count` unchanged.
- All PC arithmetic is 32-bit modulo 2^32, so `fetch_pc` wraps from 32'hFFFF_FFFC to 32'h0.
- IDLE:
  - Goes to WAIT when `count_next` < DEPTH and !`redirect`.
  - With `redirect`, loads `fetch_pc` and stays in IDLE for one cycle.
- WAIT:
  - `imem_req`=1 and `imem_addr`=`fetch_pc`.
  - On ack: push, then stay in WAIT if `count_next` < DEPTH, else go to IDLE. With a zero-wait memory this gives back-to-back fetch at 1 word/cycle.
  - `redirect` without ack: go to DROP.
  - `redirect` with ack: discard the data, load `fetch_pc`, go to IDLE.
- DROP:
  - `imem_req` stays high with the old address (the request may not be withdrawn).
  - On ack, the data is discarded and the block goes to IDLE.
  - A further `redirect` while in DROP overwrites `fetch_pc` and stays in DROP.
- Redirect:
  - Highest priority over push and pop in the same cycle.
  - Clears `count` and both pointers and loads `redirect_pc` into `fetch_pc`.
- Full FIFO: a request is issued only when space is guaranteed, so a push never finds the FIFO full. No overflow is possible.
- Empty FIFO: `ins_valid`=0. `ins_out` and `ins_pc4` show the stale entry and must not be used.
- `ins_ready` asserted while `ins_valid`=0 is ignored.

## Timing
- Reset values (all outputs and state):
  - `imem_req`=0, `imem_addr`=RESET_PC.
  - `ins_valid`=0, `ins_out`=0, `ins_pc4`=0.
  - `fetch_pc`=RESET_PC, state IDLE, `count`=0, storage zeroed.
- `rst` mid-operation: a pending ack in the reset cycle is ignored. The memory side must tolerate a withdrawn request on reset.
- After reset:
  - The first cycle after `rst` falls is IDLE.
  - `imem_req` rises at the next edge.
- Latency:
  - An ack in cycle N gives `ins_valid`=1 in N+1 (registered).
  - Redirect in cycle N: `ins_valid`=0 in N+1; the earliest new request is in N+2.
- All outputs are driven from registers except in the bypass configuration below.

## Configuration
- `IF_PREFETCH_BYPASS_EN` defined:
  - Applies when `count`=0, an ack is accepted in WAIT, and `redirect`=0.
  - In that cycle `ins_valid`, `ins_out` and `ins_pc4` combinationally present `imem_rdata` and `fetch_pc`+4. Ack-to-valid latency is 0 cycles.
  - If `ins_ready` is also high, the word is consumed and not pushed; otherwise it is pushed normally.
- Undefined: the output path is purely registered with 1-cycle latency, as specified above.

## Test plan
- Reset, ack tied high, `ins_ready`=1, RESET_PC=0 -> addresses 0,4,8,... issued on consecutive cycles; ins_pc4 = 4,8,12,...; one word per cycle.
- `ins_ready`=0, ack always high, DEPTH=4 -> exactly 4 pushes, `imem_req` drops, FIFO holds addresses 0..12; release `ins_ready` -> fetch resumes at 16.
- Ack delayed 3 cycles; `redirect`=1 to 32'h100 in the second wait cycle -> stale ack data discarded, FIFO empty, next request address 32'h100, first delivered ins_pc4 = 32'h104.
- Redirect and ack in the same cycle with the FIFO holding 2 entries -> `count`=0 next cycle, no push, `imem_addr`=redirect_pc on the next request.
- `fetch_pc`=32'hFFFF_FFFC fetched -> ins_pc4=0, next fetch address 0.
- With `IF_PREFETCH_BYPASS_EN`: FIFO empty, ack with rdata 32'h2002_0005 -> `ins_valid`=1 and `ins_out`=32'h2002_0005 in the same cycle; `count` remains 0 when `ins_ready`=1.
